// File: rtl/sm4_issue_ctrl.sv
// sm4_issue_ctrl
// Issue and writeback controller for the SM4 crypto functional unit.
// One sm4ed/sm4ks request is accepted at a time. Its operands are driven
// onto four independent valid/ready channels (A, B, byte select and
// operation). The controller then waits, under a watchdog, for the unit's
// result and hands it to writeback tagged with the destination register.
// A flush marks the in-flight instruction as killed. The unit is still
// drained, but the result is dropped.
//
// Optional feature: define SM4_ISSUE_RESULT_CACHE_EN to add a one-entry
// result cache. A repeated request is then answered without using the unit.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake from the execute stage
//   req_op, req_rs1, req_rs2  operation (0=ED, 1=KS) and source operands
//   req_bs, req_rd            byte select and destination tag
//   flush                     kill the current instruction
//   m_axis_a_*                operand A channel to the unit (32 bit)
//   m_axis_b_*                operand B channel to the unit (32 bit)
//   m_axis_bs_*               byte-select channel to the unit (2 bit)
//   m_axis_operation_*        operation channel to the unit (1 bit)
//   s_axis_result_*           result from the unit (no back-pressure)
//   wb_valid, wb_rd, wb_data  writeback pulse, tag and data
//   busy                      controller not idle; the pipeline stalls
//   err_timeout               one-cycle pulse when a request is abandoned
module sm4_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RD_W           = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [1:0]      req_bs,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic            m_axis_a_tvalid,
    input  logic            m_axis_a_tready,
    output logic [31:0]     m_axis_a_tdata,
    output logic            m_axis_b_tvalid,
    input  logic            m_axis_b_tready,
    output logic [31:0]     m_axis_b_tdata,
    output logic            m_axis_bs_tvalid,
    input  logic            m_axis_bs_tready,
    output logic [1:0]      m_axis_bs_tdata,
    output logic            m_axis_operation_tvalid,
    input  logic            m_axis_operation_tready,
    output logic            m_axis_operation_tdata,
    input  logic            s_axis_result_tvalid,
    input  logic [31:0]     s_axis_result_tdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            busy,
    output logic            err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t          state;
    logic [RD_W-1:0] rd_hold;
    logic            killed;
    logic [CNT_W-1:0] wd_cnt;
    logic            wb_pulse;
    logic [3:0]      pend_next;

    // The tvalid registers double as the pending bits. A bit stays set until its handshake.
    assign pend_next = {m_axis_a_tvalid         & ~m_axis_a_tready,
                        m_axis_b_tvalid         & ~m_axis_b_tready,
                        m_axis_bs_tvalid        & ~m_axis_bs_tready,
                        m_axis_operation_tvalid & ~m_axis_operation_tready};

    assign req_ready = (state == IDLE) && !flush;
    assign busy      = (state != IDLE);
    // The registered pulse is dropped by a flush that arrives in the WB cycle itself.
    assign wb_valid  = wb_pulse && !flush;

`ifdef SM4_ISSUE_RESULT_CACHE_EN
    logic        cache_valid;
    logic        cache_op;
    logic [31:0] cache_rs1;
    logic [31:0] cache_rs2;
    logic [1:0]  cache_bs;
    logic [31:0] cache_result;
    logic        cache_hit;

    // The incoming request matches the cached operand tuple.
    always_comb begin
        cache_hit = 1'b0;
        if (cache_valid && (req_op == cache_op) && (req_rs1 == cache_rs1) &&
            (req_rs2 == cache_rs2) && (req_bs == cache_bs)) begin
            cache_hit = 1'b1;
        end else begin
            cache_hit = 1'b0;
        end
    end
`endif

    // Controller FSM with its registered channel, writeback and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            m_axis_a_tvalid         <= 1'b0;
            m_axis_b_tvalid         <= 1'b0;
            m_axis_bs_tvalid        <= 1'b0;
            m_axis_operation_tvalid <= 1'b0;
            m_axis_a_tdata          <= 32'h0000_0000;
            m_axis_b_tdata          <= 32'h0000_0000;
            m_axis_bs_tdata         <= 2'b00;
            m_axis_operation_tdata  <= 1'b0;
            rd_hold                 <= '0;
            killed                  <= 1'b0;
            wd_cnt                  <= '0;
            wb_pulse                <= 1'b0;
            wb_rd                   <= '0;
            wb_data                 <= 32'h0000_0000;
            err_timeout             <= 1'b0;
`ifdef SM4_ISSUE_RESULT_CACHE_EN
            cache_valid             <= 1'b0;
            cache_op                <= 1'b0;
            cache_rs1               <= 32'h0000_0000;
            cache_rs2               <= 32'h0000_0000;
            cache_bs                <= 2'b00;
            cache_result            <= 32'h0000_0000;
`endif
        end else begin
            wb_pulse    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        m_axis_a_tdata         <= req_rs1;
                        m_axis_b_tdata         <= req_rs2;
                        m_axis_bs_tdata        <= req_bs;
                        m_axis_operation_tdata <= req_op;
                        rd_hold                <= req_rd;
                        killed                 <= 1'b0;
                        wd_cnt                 <= '0;
`ifdef SM4_ISSUE_RESULT_CACHE_EN
                        if (cache_hit) begin
                            // Answer from the cache without using the unit.
                            wb_data  <= cache_result;
                            wb_rd    <= req_rd;
                            wb_pulse <= 1'b1;
                            state    <= WB;
                        end else begin
                            m_axis_a_tvalid         <= 1'b1;
                            m_axis_b_tvalid         <= 1'b1;
                            m_axis_bs_tvalid        <= 1'b1;
                            m_axis_operation_tvalid <= 1'b1;
                            state                   <= ISSUE;
                        end
`else
                        m_axis_a_tvalid         <= 1'b1;
                        m_axis_b_tvalid         <= 1'b1;
                        m_axis_bs_tvalid        <= 1'b1;
                        m_axis_operation_tvalid <= 1'b1;
                        state                   <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    // Flush only marks the instruction; tvalids are never withdrawn early.
                    {m_axis_a_tvalid, m_axis_b_tvalid,
                     m_axis_bs_tvalid, m_axis_operation_tvalid} <= pend_next;
                    if (flush) begin
                        killed <= 1'b1;
                    end
                    if (pend_next == 4'b0000) begin
                        wd_cnt <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        killed <= 1'b1;
                    end
                    // A result in the last watchdog cycle still takes priority.
                    if (s_axis_result_tvalid) begin
                        wb_data  <= s_axis_result_tdata;
                        wb_rd    <= rd_hold;
                        wb_pulse <= !killed && !flush;
                        state    <= WB;
`ifdef SM4_ISSUE_RESULT_CACHE_EN
                        cache_valid  <= 1'b1;
                        cache_op     <= m_axis_operation_tdata;
                        cache_rs1    <= m_axis_a_tdata;
                        cache_rs2    <= m_axis_b_tdata;
                        cache_bs     <= m_axis_bs_tdata;
                        cache_result <= s_axis_result_tdata;
`endif
                    end else if (wd_cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        wd_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                WB: begin
                    if (flush) begin
                        killed <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_issue_ctrl.sv
// Self-checking bench for sm4_issue_ctrl. A stub SM4 unit returns
// rs1^rs2 five cycles after the last channel handshake. Expected
// writebacks are queued when a request is sent, and a monitor retires
// them whenever wb_valid is seen.
module tb_sm4_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [1:0]  req_bs;
    logic [4:0]  req_rd;
    logic        flush;
    logic        a_tvalid, a_tready, b_tvalid, b_tready;
    logic        bs_tvalid, bs_tready, op_tvalid, op_tready;
    logic [31:0] a_tdata, b_tdata;
    logic [1:0]  bs_tdata;
    logic        op_tdata;
    logic        res_tvalid;
    logic [31:0] res_tdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        err_timeout;
    logic [3:0]  tv4;

    int errors = 0;
    int checks = 0;
    int now_c  = 0;
    logic [36:0] sb_q[$];

    // stub state
    logic [7:0]  dly_a, dly_b, dly_bs, dly_op;
    logic [7:0]  rel, res_at;
    logic [3:0]  hs, hs_now;
    logic [31:0] sa, sb;
    logic        respond;

    always #5 clk = ~clk;

    sm4_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_bs(req_bs), .req_rd(req_rd),
        .flush(flush),
        .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_tready), .m_axis_a_tdata(a_tdata),
        .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_tready), .m_axis_b_tdata(b_tdata),
        .m_axis_bs_tvalid(bs_tvalid), .m_axis_bs_tready(bs_tready), .m_axis_bs_tdata(bs_tdata),
        .m_axis_operation_tvalid(op_tvalid), .m_axis_operation_tready(op_tready),
        .m_axis_operation_tdata(op_tdata),
        .s_axis_result_tvalid(res_tvalid), .s_axis_result_tdata(res_tdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    assign tv4       = {a_tvalid, b_tvalid, bs_tvalid, op_tvalid};
    assign a_tready  = (rel >= dly_a);
    assign b_tready  = (rel >= dly_b);
    assign bs_tready = (rel >= dly_bs);
    assign op_tready = (rel >= dly_op);
    assign hs_now    = {a_tvalid & a_tready, b_tvalid & b_tready,
                        bs_tvalid & bs_tready, op_tvalid & op_tready};
    assign res_tvalid = respond && (hs == 4'hF) && (rel == res_at);
    assign res_tdata  = sa ^ sb;

    // Stub SM4 unit: rel counts cycles since accept; result 5 cycles after the last handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rel    <= 8'd0;
            hs     <= 4'hF;
            res_at <= 8'hFF;
            sa     <= 32'h0;
            sb     <= 32'h0;
        end else begin
            if (req_valid && req_ready) begin
                rel    <= 8'd1;
                hs     <= 4'h0;
                res_at <= 8'hFF;
            end else begin
                rel <= (rel >= 8'hFE) ? rel : rel + 8'd1;
                hs  <= hs | hs_now;
                if (hs != 4'hF && (hs | hs_now) == 4'hF) res_at <= rel + 8'd5;
            end
            if (hs_now[3]) sa <= a_tdata;
            if (hs_now[2]) sb <= b_tdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic to_cyc(input int k);
        repeat (k - now_c) @(negedge clk);
        now_c = k;
    endtask

    task automatic send(input logic [31:0] rs1, input logic [31:0] rs2, input logic [1:0] bs,
                        input logic op, input logic [4:0] rd, input logic push,
                        input logic [31:0] exp);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_bs = bs; req_op = op; req_rd = rd;
        @(negedge clk);
        chk("req_ready_accept", 64'(req_ready), 64'h1);
        if (push) sb_q.push_back({rd, exp});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        now_c = 0;
    endtask

    task automatic set_dly(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] s, input logic [7:0] o);
        dly_a = a; dly_b = b; dly_bs = s; dly_op = o;
    endtask

    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (!rst && wb_valid) begin
                if (sb_q.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_valid), 64'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wb_rd_data", 64'({wb_rd, wb_data}), 64'(e));
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_rs1 = 32'h0; req_rs2 = 32'h0;
        req_bs = 2'd0; req_rd = 5'd0; flush = 1'b0; respond = 1'b1;
        set_dly(8'd1, 8'd1, 8'd1, 8'd1);
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", 64'({wb_valid, busy, err_timeout, tv4}), 64'h0);
        chk("rst_tdata", 64'({a_tdata, bs_tdata, op_tdata}), 64'h0);
        chk("rst_wb", 64'({wb_rd, wb_data}), 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h1);

        // basic request, all channels accepted in cycle 1
        send(32'h12345678, 32'h0F0F0F0F, 2'd2, 1'b0, 5'd7, 1'b1, 32'h1D3B5977);
        to_cyc(1);
        chk("t1_tvalid_c1", 64'(tv4), 64'hF);
        chk("t1_a_tdata", 64'(a_tdata), 64'h12345678);
        chk("t1_bs_op_tdata", 64'({bs_tdata, op_tdata}), 64'h4);
        to_cyc(2);
        chk("t1_wait_c2", 64'({busy, tv4}), 64'h10);
        to_cyc(6);
        chk("t1_wb_c6", 64'(wb_valid), 64'h0);
        to_cyc(7);
        chk("t1_wb_c7", 64'(wb_valid), 64'h1);
        to_cyc(8);
        chk("t1_idle_c8", 64'({req_ready, busy}), 64'h2);

        // staggered channel acceptance
        set_dly(8'd1, 8'd3, 8'd2, 8'd4);
        send(32'hA5A5A5A5, 32'h0000FFFF, 2'd1, 1'b1, 5'd3, 1'b1, 32'hA5A55A5A);
        to_cyc(1);
        chk("t2_tvalid_c1", 64'(tv4), 64'hF);
        chk("t2_b_op_tdata", 64'({b_tdata, op_tdata}), 64'h1FFFF);
        to_cyc(2);
        chk("t2_tvalid_c2", 64'(tv4), 64'h7);
        to_cyc(3);
        chk("t2_tvalid_c3", 64'(tv4), 64'h5);
        to_cyc(4);
        chk("t2_tvalid_c4", 64'(tv4), 64'h1);
        to_cyc(5);
        chk("t2_wait_c5", 64'({busy, tv4}), 64'h10);
        to_cyc(9);
        chk("t2_wb_c9", 64'(wb_valid), 64'h0);
        to_cyc(10);
        chk("t2_wb_c10", 64'(wb_valid), 64'h1);
        to_cyc(11);

        // flush during WAIT: result dropped, unit still drained
        set_dly(8'd1, 8'd1, 8'd1, 8'd1);
        send(32'h11111111, 32'h22222222, 2'd0, 1'b0, 5'd9, 1'b0, 32'h0);
        to_cyc(2);
        flush = 1'b1;
        to_cyc(3);
        flush = 1'b0;
        to_cyc(7);
        chk("t3_killed_wb_c7", 64'({wb_valid, busy}), 64'h1);
        to_cyc(8);
        chk("t3_busy_c8", 64'(busy), 64'h0);
        // flush in IDLE blocks acceptance
        req_valid = 1'b1; flush = 1'b1; req_rs1 = 32'h5; req_rs2 = 32'h6;
        #1 chk("t3_flush_idle_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        chk("t3_flush_idle_busy", 64'(busy), 64'h0);
        req_valid = 1'b0; flush = 1'b0;
        send(32'hFFFF0000, 32'h0F0F0F0F, 2'd0, 1'b0, 5'd12, 1'b1, 32'hF0F00F0F);
        to_cyc(7);
        chk("t3_next_wb_c7", 64'(wb_valid), 64'h1);
        to_cyc(8);

        // unit never responds: watchdog
        respond = 1'b0;
        send(32'hDEADBEEF, 32'h01234567, 2'd3, 1'b1, 5'd20, 1'b0, 32'h0);
        to_cyc(17);
        chk("t4_no_err_c17", 64'({err_timeout, busy}), 64'h1);
        to_cyc(18);
        chk("t4_err_c18", 64'(err_timeout), 64'h1);
        to_cyc(19);
        chk("t4_after_c19", 64'({err_timeout, req_ready, wb_valid}), 64'h2);
        respond = 1'b1;

        // asynchronous reset while channels are being issued
        set_dly(8'd10, 8'd10, 8'd10, 8'd10);
        send(32'hCAFEF00D, 32'h13572468, 2'd1, 1'b0, 5'd5, 1'b0, 32'h0);
        to_cyc(2);
        chk("t5_tvalid_c2", 64'(tv4), 64'hF);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", 64'({wb_valid, busy, err_timeout, tv4}), 64'h0);
        chk("t5_rst_tdata", 64'({a_tdata, bs_tdata}), 64'h0);
        chk("t5_rst_wb", 64'({wb_rd, wb_data}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        set_dly(8'd1, 8'd1, 8'd1, 8'd1);
        send(32'h00000001, 32'h80000000, 2'd0, 1'b0, 5'd31, 1'b1, 32'h80000001);
        to_cyc(7);
        chk("t5_recover_wb_c7", 64'(wb_valid), 64'h1);
        to_cyc(8);

`ifdef SM4_ISSUE_RESULT_CACHE_EN
        // identical request hits the cache
        send(32'h00000001, 32'h80000000, 2'd0, 1'b0, 5'd30, 1'b1, 32'h80000001);
        to_cyc(1);
        chk("t6_hit_c1", 64'({wb_valid, tv4}), 64'h10);
        to_cyc(2);
        chk("t6_hit_idle_c2", 64'(busy), 64'h0);
        // different byte select misses
        send(32'h00000001, 32'h80000000, 2'd3, 1'b0, 5'd29, 1'b1, 32'h80000001);
        to_cyc(1);
        chk("t6_miss_c1", 64'({wb_valid, tv4}), 64'hF);
        to_cyc(7);
        chk("t6_miss_wb_c7", 64'(wb_valid), 64'h1);
        to_cyc(8);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
